// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, R-type
// functs, controller states and datapath select encodings.
package mips_mc_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_R    = 6'd0,
    OP_J    = 6'd2,
    OP_BEQ  = 6'd4,
    OP_ADDI = 6'd8,
    OP_LW   = 6'd35,
    OP_SW   = 6'd43
  } op_code_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'd32,
    FN_SUB = 6'd34,
    FN_AND = 6'd36,
    FN_OR  = 6'd37,
    FN_SLT = 6'd42
  } funct_e;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_e;

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unknown functs.
module mips_mc_ctrl_alu_dec
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       valid
);

  // Funct lookup; unknown codes report invalid and park the ALU on ADD.
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit. Moore FSM over the controller states; the only
// input-dependent outputs are the fetch-completion write pulses and the branch
// PC write. Write enables are forced low while rst_n is asserted.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1,
  parameter int RET_CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 trap,
  output logic [3:0]           state_o,
  output logic [RET_CNT_W-1:0] ret_cnt
);

  // Where an unrecognised opcode or funct ends up.
  localparam ctrl_state_e ILLEGAL_ST = TRAP_ILLEGAL ? ST_TRAP : ST_FETCH;

  ctrl_state_e          state_q, state_d;
  logic [RET_CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  alu_op_e              dec_op_s;
  logic                 dec_valid_s;
  logic                 mem_done_s;
  logic                 mem_req_s, mem_we_s, iord_s, ir_we_s, pc_we_s, reg_we_s;
  logic                 reg_dst_s, mem_to_reg_s, alu_src_a_s, trap_s;
  alu_op_e              alu_op_s;
  pc_src_e              pc_src_s;
  alu_src_b_e           alu_src_b_s;

  mips_mc_ctrl_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (dec_op_s),
    .valid  (dec_valid_s)
  );

  // Without a handshake every memory access completes in its first cycle.
  assign mem_done_s = mem_ready | ~MEM_HANDSHAKE;

  // State and retired-count registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ret_cnt_q <= {RET_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Next-state, datapath controls and retire counting.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    trap_s       = 1'b0;
    alu_op_s     = ALU_ADD;
    pc_src_s     = PC_ALU;
    alu_src_b_s  = SRCB_B;
    case (state_q)
      ST_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        if (mem_done_s) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_b_s = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ILLEGAL_ST;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_d = ST_MEMRD;
        end else begin
          state_d = ST_MEMWR;
        end
      end
      ST_MEMRD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (mem_done_s) begin
          state_d = ST_MEMWB;
        end else begin
          state_d = ST_MEMRD;
        end
      end
      ST_MEMWB: begin
        reg_we_s     = 1'b1;
        mem_to_reg_s = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
        if (mem_done_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEMWR;
        end
      end
      ST_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = dec_op_s;
        if (dec_valid_s) begin
          state_d = ST_ALUWB;
        end else begin
          state_d = ILLEGAL_ST;
        end
      end
      ST_ALUWB: begin
        reg_we_s  = 1'b1;
        reg_dst_s = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_SUB;
        pc_src_s    = PC_ALUOUT;
        pc_we_s     = zero;
        state_d     = ST_FETCH;
      end
      ST_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        state_d     = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_we_s = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_s = PC_JUMP;
        pc_we_s  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: begin
        trap_s  = 1'b1;
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
      ret_cnt_d = ret_cnt_q + {{(RET_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ret_cnt_d = ret_cnt_q;
    end
  end

  assign mem_req    = mem_req_s;
  assign mem_we     = mem_we_s & rst_n;
  assign iord       = iord_s;
  assign ir_we      = ir_we_s & rst_n;
  assign pc_we      = pc_we_s & rst_n;
  assign pc_src     = pc_src_s;
  assign reg_we     = reg_we_s & rst_n;
  assign reg_dst    = reg_dst_s;
  assign mem_to_reg = mem_to_reg_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign alu_op     = alu_op_s;
  assign trap       = trap_s;
  assign state_o    = state_q;
  assign ret_cnt    = ret_cnt_q;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback for the supported instruction set.
- Drives datapath mux selects and enables, plus a memory request/ready handshake.
- Supersedes the fixed four-opcode decode with parametrised memory wait, illegal-opcode policy and a retired-instruction counter.
- Sits between the instruction register and the datapath in the core top level.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states hold until mem_ready; 0 = memory is single-cycle and mem_ready is ignored.
- TRAP_ILLEGAL, 1: 1 = an unknown opcode or funct enters TRAP and stays there; 0 = it is retired as a NOP.
- RET_CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], opCodeType.
- funct  in  6  IR[5:0], funcType.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC write; already includes the branch condition.
- pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
- reg_we  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  3  aluOpType.
- trap  out  1  high while in TRAP.
- state_o  out  4  current state, for debug.
- ret_cnt  out  RET_CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n low): state = FETCH, ret_cnt = 0. All registered outputs are 0 except those that are combinational from state, which take FETCH decode. trap = 0.
- Reset asserted mid-access aborts the access immediately. No write enable may be high during reset.
- Opcodes: R=0, J=2, BEQ=4, ADDI=8, LW=35, SW=43.
- R-type functs: ADD, SUB, AND, OR, SLT.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_we and pc_we pulse only in the cycle the access completes (mem_ready=1, or always when MEM_HANDSHAKE=0). That cycle moves to DECODE; otherwise FETCH holds.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target precompute). Next state by opcode:
  - LW/SW -> MEMADR
  - R -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other -> TRAP if TRAP_ILLEGAL, else FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Waits on handshake, then -> MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Waits on handshake, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op decoded from funct. Unknown funct is handled as an illegal opcode. Otherwise -> ALUWB.
- ALUWB: reg_we=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_we=zero. -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, ADD. -> ADDIWB.
- ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- JUMP: pc_src=2, pc_we=1. -> FETCH.
- TRAP: all enables 0, trap=1. Held until reset.
- ret_cnt:
  - Increments by 1 on each transition into FETCH from a non-FETCH state, including the illegal-NOP path.
  - Does not increment when leaving reset.
  - Wraps modulo 2^RET_CNT_W.
- Handshake: mem_req stays high and mem_we/iord stay stable until mem_ready. mem_ready sampled outside a memory state is ignored.
- Latency in cycles with zero wait states: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.

Decomposition:
- Additions to the shared def package:
  - opCodeType gains J, BEQ, ADDI.
  - ctrlStateType enum, 4-bit.
  - aluOpType enum: ADD, SUB, AND, OR, SLT.
  - pcSrcType and aluSrcBType enums.
- Natural sub-module: mips_alu_dec, combinational, mapping funct to aluOpType plus a valid flag. It is used in the EXEC decode.

Test Plan:
- R-type ADD (op=0, funct=ADD), MEM_HANDSHAKE=0 -> states FETCH, DECODE, EXEC, ALUWB, FETCH. reg_we=1 and reg_dst=1 only in ALUWB; ret_cnt 0 -> 1.
- LW, mem_ready low for 3 cycles in MEMRD -> mem_req=1 and iord=1 held for 4 cycles, then MEMWB with reg_we=1, mem_to_reg=1. Total 8 cycles.
- BEQ with zero=1 -> pc_we=1 and pc_src=1 in BRANCH. With zero=0 -> pc_we=0 and the path still returns to FETCH.
- Opcode 6'd63:
  - TRAP_ILLEGAL=1 -> TRAP, trap=1 held for 20 cycles, no enables.
  - TRAP_ILLEGAL=0 -> FETCH after DECODE, ret_cnt increments.
- rst_n low mid-MEMWR -> same cycle: mem_we=0, state_o=FETCH, ret_cnt=0.
- RET_CNT_W=4, 17 J instructions -> ret_cnt=1 (wrap).
